pio_request_servicer: RTL

Avalon-MM master that services the single-bit request PIO (s1 slave: data at address 0, irq mask at address 2) from the hardware side instead of the Nios II. It arms the PIO interrupt, waits for `irq`, masks it, reads the data register, and hands each confirmed request to fabric logic over a valid/ready handshake. It re-arms the interrupt only after the request has been consumed. It sits between the request PIO slave and the game-logic request consumer, and keeps saturating request and spurious-interrupt counters.

---
 rtl/pio_request_servicer.sv | 118 +++++++++++
 1 files changed

// File: rtl/pio_request_servicer.sv
// Avalon-MM master that services the request PIO interrupt in hardware and hands requests to fabric.
// Optional irq debounce is enabled by defining PIO_REQUEST_SERVICER_DEBOUNCE_EN.
module pio_request_servicer #(
  parameter int COUNT_W         = 16,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               irq,
  output logic [1:0]         address,
  output logic               chipselect,
  output logic               write_n,
  output logic [31:0]        writedata,
  input  logic [31:0]        readdata,
  output logic               req_valid,
  input  logic               req_ready,
  output logic [COUNT_W-1:0] req_count,
  output logic [COUNT_W-1:0] spurious_count,
  output logic               busy
);

  localparam logic [2:0] INIT_WR   = 3'd0;
  localparam logic [2:0] IDLE      = 3'd1;
  localparam logic [2:0] DEBOUNCE  = 3'd2;
  localparam logic [2:0] MASK_WR   = 3'd3;
  localparam logic [2:0] RD_ADDR   = 3'd4;
  localparam logic [2:0] RD_WAIT   = 3'd5;
  localparam logic [2:0] PRESENT   = 3'd6;
  localparam logic [2:0] UNMASK_WR = 3'd7;

  logic [2:0] state;
  logic [2:0] state_d;
  logic       unused_readdata;

  assign unused_readdata = ^readdata[31:1];

  function automatic logic [COUNT_W-1:0] sat_inc(input logic [COUNT_W-1:0] v);
    return (&v) ? v : v + {{(COUNT_W-1){1'b0}}, 1'b1};
  endfunction

`ifdef PIO_REQUEST_SERVICER_DEBOUNCE_EN
  logic [7:0] db_cnt;
`else
  localparam int unused_db_cycles = DEBOUNCE_CYCLES;
`endif

  always_comb begin
    state_d = state;
    case (state)
      // INIT_WR holds until its write has actually been driven on the bus
      INIT_WR:   if (chipselect) state_d = IDLE;
`ifdef PIO_REQUEST_SERVICER_DEBOUNCE_EN
      IDLE:      if (irq) state_d = DEBOUNCE;
      DEBOUNCE: begin
        if (!irq)                                   state_d = IDLE;
        else if (db_cnt == 8'(DEBOUNCE_CYCLES - 1)) state_d = MASK_WR;
      end
`else
      IDLE:      if (irq) state_d = MASK_WR;
`endif
      MASK_WR:   state_d = RD_ADDR;
      RD_ADDR:   state_d = RD_WAIT;
      RD_WAIT:   state_d = readdata[0] ? PRESENT : UNMASK_WR;
      PRESENT:   if (req_ready) state_d = UNMASK_WR;
      UNMASK_WR: state_d = IDLE;
      default:   state_d = INIT_WR;
    endcase
  end

  // Bus outputs are registered from the state being entered so they line up with it
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= INIT_WR;
      address        <= 2'd0;
      chipselect     <= 1'b0;
      write_n        <= 1'b1;
      writedata      <= 32'd0;
      req_valid      <= 1'b0;
      req_count      <= '0;
      spurious_count <= '0;
      busy           <= 1'b1;
    end else begin
      state      <= state_d;
      busy       <= (state_d != IDLE);
      req_valid  <= (state_d == PRESENT);
      address    <= 2'd0;
      chipselect <= 1'b0;
      write_n    <= 1'b1;
      writedata  <= 32'd0;
      case (state_d)
        INIT_WR, UNMASK_WR: begin
          address    <= 2'd2;
          chipselect <= 1'b1;
          write_n    <= 1'b0;
          writedata  <= 32'd1;
        end
        MASK_WR: begin
          address    <= 2'd2;
          chipselect <= 1'b1;
          write_n    <= 1'b0;
        end
        RD_ADDR:  chipselect <= 1'b1;
        default: ;
      endcase
      if (state == RD_WAIT && !readdata[0]) spurious_count <= sat_inc(spurious_count);
      if (state == PRESENT && req_ready)    req_count      <= sat_inc(req_count);
    end
  end

`ifdef PIO_REQUEST_SERVICER_DEBOUNCE_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                        db_cnt <= 8'd0;
    else if (state == DEBOUNCE && irq) db_cnt <= db_cnt + 8'd1;
    else                              db_cnt <= 8'd0;
  end
`endif

endmodule
